inv_table_lookup: RTL and testbench

- Decryption-side counterpart of the forward T-table lookup. Takes one 32-bit AES state column and produces four 32-bit partial words p0..p3. XOR of p0..p3 = InvMixColumns(InvSubBytes(column)).
- When `last` is set, the XOR instead yields InvSubBytes(column) with no InvMixColumns. This serves the final decryption round.
- Two-stage registered pipeline with valid/ready handshake on both sides. Sits between the decryption round-state register and the round-key XOR.

---
 rtl/inv_table_lookup_pkg.sv | 74 +++++++
 rtl/inv_table_lookup_inv_s.sv | 31 +++
 rtl/inv_table_lookup.sv | 117 +++++++++++
 tb/tb_inv_table_lookup.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_table_lookup_pkg.sv
// Shared types, GF(2^8) constants and helpers for the inverse T-table lookup.
package inv_table_lookup_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned COL_W   = 32;
   localparam int unsigned N_LANES = 4;

   // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1
   localparam logic [BYTE_W-1:0] GF_RED = 8'h1b;

   // InvMixColumns coefficients; only the low nibble is ever non-zero
   localparam logic [3:0] COEF_0E = 4'he;
   localparam logic [3:0] COEF_09 = 4'h9;
   localparam logic [3:0] COEF_0D = 4'hd;
   localparam logic [3:0] COEF_0B = 4'hb;

   // Lane 0 is the most significant byte of the column (b0)
   typedef logic [0:N_LANES-1][BYTE_W-1:0] lanes_t;

   // Stage-1 payload: inverse-substituted bytes plus the final-round flag
   typedef struct packed {
      lanes_t s;
      logic   last;
   } s1_payload_t;

   // Multiply by x in GF(2^8)
   function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
   endfunction

   // Multiply by a 4-bit constant using the x2/x4/x8 xtime chain
   function automatic logic [BYTE_W-1:0] gf_mul_coef(input logic [BYTE_W-1:0] s,
                                                      input logic [3:0]        c);
      logic [BYTE_W-1:0] x2, x4, x8;
      x2 = xtime(s);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return ({BYTE_W{c[0]}} & s)  ^ ({BYTE_W{c[1]}} & x2) ^
             ({BYTE_W{c[2]}} & x4) ^ ({BYTE_W{c[3]}} & x8);
   endfunction

   // Td(s) = {0e*s, 09*s, 0d*s, 0b*s}
   function automatic logic [COL_W-1:0] td_word(input logic [BYTE_W-1:0] s);
      return {gf_mul_coef(s, COEF_0E), gf_mul_coef(s, COEF_09),
              gf_mul_coef(s, COEF_0D), gf_mul_coef(s, COEF_0B)};
   endfunction

   // Rotate a column right by n bytes
   function automatic logic [COL_W-1:0] rotr_bytes(input logic [COL_W-1:0] w,
                                                   input logic [1:0]       n);
      logic [COL_W-1:0] r;
      case (n)
         2'd0:    r = w;
         2'd1:    r = {w[7:0],  w[31:8]};
         2'd2:    r = {w[15:0], w[31:16]};
         default: r = {w[23:0], w[31:24]};
      endcase
      return r;
   endfunction

   // Place a byte in lane n of an otherwise zero column
   function automatic logic [COL_W-1:0] place_lane(input logic [BYTE_W-1:0] s,
                                                   input logic [1:0]        n);
      logic [COL_W-1:0] r;
      case (n)
         2'd0:    r = {s, 24'h000000};
         2'd1:    r = {8'h00, s, 16'h0000};
         2'd2:    r = {16'h0000, s, 8'h00};
         default: r = {24'h000000, s};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/inv_table_lookup_inv_s.sv
// Purely combinational AES inverse S-box.
module inv_s
   import inv_table_lookup_pkg::*;
(
   input  logic [BYTE_W-1:0] a_i,
   output logic [BYTE_W-1:0] s_o
);

   localparam logic [0:255][7:0] INV_SBOX = {
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Table lookup
   assign s_o = INV_SBOX[a_i];

endmodule

// File: rtl/inv_table_lookup.sv
// Two-stage inverse T-table lookup: InvSubBytes in stage 1, Td partial words in stage 2.
module inv_table_lookup
   import inv_table_lookup_pkg::*;
#(
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      state,
   input  logic             last,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      p0,
   output logic [31:0]      p1,
   output logic [31:0]      p2,
   output logic [31:0]      p3,
   output logic [TAG_W-1:0] tag_out
);

   lanes_t            in_lanes;
   logic [BYTE_W-1:0] sb_byte [N_LANES];

   logic              s1_valid_q, s1_valid_d;
   s1_payload_t       s1_q, s1_d;
   logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

   logic              out_valid_q, out_valid_d;
   logic [COL_W-1:0]  p_q [N_LANES];
   logic [COL_W-1:0]  p_d [N_LANES];
   logic [TAG_W-1:0]  tag_out_q, tag_out_d;

   logic              adv_c;

   assign in_lanes = state;

   // One inverse S-box per byte lane
   for (genvar g = 0; g < N_LANES; g++) begin : g_sbox
      inv_s u_inv_s (
         .a_i (in_lanes[g]),
         .s_o (sb_byte[g])
      );
   end

   // Stage 2 may load when empty or when its contents are being taken
   assign adv_c    = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || adv_c;

   // Stage 1 next state: capture substituted bytes on accept, drain into stage 2
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      s1_tag_d   = s1_tag_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            for (int i = 0; i < N_LANES; i++) begin
               s1_d.s[i] = sb_byte[i];
            end
            s1_d.last = last;
            s1_tag_d  = tag_in;
         end
      end
   end

   // Stage 2 next state: Td rotation per lane, or bare byte placement in the final round
   always_comb begin
      out_valid_d = out_valid_q;
      tag_out_d   = tag_out_q;
      for (int i = 0; i < N_LANES; i++) begin
         p_d[i] = p_q[i];
      end
      if (adv_c) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            for (int i = 0; i < N_LANES; i++) begin
               p_d[i] = s1_q.last ? place_lane(s1_q.s[i], 2'(i))
                                  : rotr_bytes(td_word(s1_q.s[i]), 2'(i));
            end
            tag_out_d = s1_tag_q;
         end
      end
   end

   // Pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         s1_tag_q    <= '0;
         out_valid_q <= 1'b0;
         tag_out_q   <= '0;
         for (int i = 0; i < N_LANES; i++) begin
            p_q[i] <= '0;
         end
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_q        <= s1_d;
         s1_tag_q    <= s1_tag_d;
         out_valid_q <= out_valid_d;
         tag_out_q   <= tag_out_d;
         for (int i = 0; i < N_LANES; i++) begin
            p_q[i] <= p_d[i];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign p0        = p_q[0];
   assign p1        = p_q[1];
   assign p2        = p_q[2];
   assign p3        = p_q[3];
   assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_inv_table_lookup.sv
// Scoreboard bench for inv_table_lookup with an independent GF(2^8) reference model.
module tb_inv_table_lookup;

   localparam int unsigned TAG_W = 4;
   localparam int unsigned REC_W = 4*32 + TAG_W;
   typedef logic [REC_W-1:0] rec_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      state;
   logic             last;
   logic [TAG_W-1:0] tag_in;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      p0, p1, p2, p3;
   logic [TAG_W-1:0] tag_out;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_out    = 0;
   rec_t sb [$];
   logic held_v   = 1'b0;
   rec_t held;

   inv_table_lookup #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state     (state),
      .last      (last),
      .tag_in    (tag_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p0        (p0),
      .p1        (p1),
      .p2        (p2),
      .p3        (p3),
      .tag_out   (tag_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input rec_t got, input rec_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference arithmetic: shift-and-add multiply, inverse by x^254, inverse affine map
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, r;
      a = a_in; b = b_in; r = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) r = r ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = {1'b0, b[7:1]};
      end
      return r;
   endfunction

   function automatic logic [7:0] ref_inv_s(input logic [7:0] x);
      logic [7:0] y, r;
      y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      r = 8'h01;
      for (int k = 0; k < 254; k++) r = gmul(r, y);
      return r;
   endfunction

   function automatic rec_t model(input logic [31:0] col, input logic lst,
                                  input logic [TAG_W-1:0] tg);
      logic [31:0] p [4];
      logic [31:0] td;
      logic [7:0]  s;
      for (int i = 0; i < 4; i++) begin
         s = ref_inv_s(col[31-8*i -: 8]);
         if (lst) begin
            p[i] = {24'h0, s} << (8*(3-i));
         end else begin
            td   = {gmul(s, 8'h0e), gmul(s, 8'h09), gmul(s, 8'h0d), gmul(s, 8'h0b)};
            p[i] = (td >> (8*i)) | (td << (32-8*i));
         end
      end
      return {p[0], p[1], p[2], p[3], tg};
   endfunction

   // Monitor: handshake sampling, in_ready rule, hold stability, scoreboard compare
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         held_v = 1'b0;
      end else begin
         chk("in_ready_rule", rec_t'(in_ready), rec_t'(!(sb.size() == 2 && !out_ready)));
         if (held_v) begin
            chk("hold_valid", rec_t'(out_valid), rec_t'(1'b1));
            chk("hold_data", {p0, p1, p2, p3, tag_out}, held);
         end
         held_v = 1'b0;
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_out", rec_t'(out_valid), rec_t'(1'b0));
            end else if (out_ready) begin
               chk("sb_data", {p0, p1, p2, p3, tag_out}, sb.pop_front());
               n_out++;
            end else begin
               held_v = 1'b1;
               held   = {p0, p1, p2, p3, tag_out};
            end
         end
         if (in_valid && in_ready) sb.push_back(model(state, last, tag_in));
      end
   end

   // Drive one column starting just after a rising edge; returns just after the accepting edge
   task automatic send(input logic [31:0] s, input logic l, input logic [TAG_W-1:0] t);
      logic ok;
      in_valid = 1'b1; state = s; last = l; tag_in = t;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("send_accept", rec_t'(in_ready), rec_t'(1'b1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      chk("wait_out", rec_t'(out_valid), rec_t'(1'b1));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base;
      logic pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

      rst_n = 1'b0; in_valid = 1'b1; state = 32'h12345678; last = 1'b0;
      tag_in = '0; out_ready = 1'b1;

      // Held in reset with in_valid asserted
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", rec_t'(out_valid), rec_t'(1'b0));
      chk("rst_outputs", {p0, p1, p2, p3, tag_out}, '0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", rec_t'(in_ready), rec_t'(1'b1));
      chk("post_rst_out_valid", rec_t'(out_valid), rec_t'(1'b0));
      @(posedge clk); #1;

      // Latency: zero column appears exactly two edges after acceptance
      send(32'h00000000, 1'b0, 4'h1);
      @(negedge clk);
      chk("lat_edge1", rec_t'(out_valid), rec_t'(1'b0));
      @(negedge clk);
      chk("lat_edge2", rec_t'(out_valid), rec_t'(1'b1));
      chk("vec_zero", rec_t'({p0, p1, p2, p3}),
          rec_t'(128'h51f4a750_5051f4a7_a75051f4_f4a75051));

      // All bytes invert to 01: partial words are the raw coefficients
      idle(3);
      send(32'h7c7c7c7c, 1'b0, 4'h2);
      wait_out();
      chk("vec_7c", rec_t'({p0, p1, p2, p3, tag_out}),
          rec_t'({128'h0e090d0b_0b0e090d_0d0b0e09_090d0b0e, 4'h2}));
      chk("vec_7c_xor", rec_t'(p0 ^ p1 ^ p2 ^ p3), rec_t'(32'h01010101));

      // Final round: bytes placed in their own lanes only
      idle(3);
      send(32'h6352007c, 1'b1, 4'h3);
      wait_out();
      chk("vec_last", rec_t'({p0, p1, p2, p3, tag_out}),
          rec_t'({128'h00000000_00480000_00005200_00000001, 4'h3}));
      chk("vec_last_xor", rec_t'(p0 ^ p1 ^ p2 ^ p3), rec_t'(32'h00485201));

      // Streaming eight tagged columns under random backpressure
      idle(3);
      base = n_out;
      fork
         begin
            for (int t = 0; t < 8; t++)
               send($urandom, 1'($urandom_range(0, 1)), 4'(t));
         end
         begin
            for (int c = 0; c < 30; c++) begin
               @(posedge clk); #1;
               out_ready = (c < 4) ? pat[c] : 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      idle(6);
      chk("stream_drained", rec_t'(sb.size()), rec_t'(0));
      chk("stream_count", rec_t'(n_out - base), rec_t'(8));

      // Reset with two columns in flight
      out_ready = 1'b0;
      send(32'hdeadbeef, 1'b0, 4'h8);
      send(32'h01234567, 1'b1, 4'h9);
      @(negedge clk);
      chk("full_in_ready", rec_t'(in_ready), rec_t'(1'b0));
      chk("inflight", rec_t'(sb.size()), rec_t'(2));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_drop", rec_t'(out_valid), rec_t'(1'b0));
      idle(2);
      rst_n = 1'b1;
      out_ready = 1'b1;
      base = n_out;
      idle(8);
      chk("no_ghost", rec_t'(n_out - base), rec_t'(0));
      chk("no_ghost_valid", rec_t'(out_valid), rec_t'(1'b0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
